// File: rtl/leaf_feeder.sv
// Leaf feeder: routes upstream records into 2*L first-word-fall-through leaf FIFOs
// and appends an all-zero terminator record to the leaf that closes each run.
module leaf_feeder #(
  parameter int L          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LEAF_W     = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_valid,
  input  logic [LEAF_W-1:0]            i_leaf,
  input  logic                         i_last,
  output logic                         o_ready,
  output logic [DATA_WIDTH*2*L-1:0]    o_fifo,
  output logic [2*L-1:0]               o_fifo_empty,
  input  logic [2*L-1:0]               i_fifo_read,
  output logic                         o_idle
);

  localparam int N     = 2 * L;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, TERM} state_t;

  state_t                  state_q, state_d;
  logic [LEAF_W-1:0]       term_leaf_q, term_leaf_d;
  logic [N-1:0]            full;
  logic                    wr_en;
  logic [LEAF_W-1:0]       wr_leaf;
  logic [DATA_WIDTH-1:0]   wr_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      term_leaf_q <= '0;
    end else begin
      state_q     <= state_d;
      term_leaf_q <= term_leaf_d;
    end
  end

  // Single write port: upstream records in IDLE, the zero terminator in TERM.
  always_comb begin
    state_d     = state_q;
    term_leaf_d = term_leaf_q;
    wr_en       = 1'b0;
    wr_leaf     = i_leaf;
    wr_data     = i_data;
    o_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = ~full[i_leaf];
        if (i_valid && o_ready) begin
          wr_en = 1'b1;
          if (i_last) begin
            term_leaf_d = i_leaf;
            state_d     = TERM;
          end
        end
      end
      TERM: begin
        wr_leaf = term_leaf_q;
        wr_data = '0;
        if (!full[term_leaf_q]) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < N; k++) begin : g_leaf
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;

    assign push                                   = wr_en && (wr_leaf == LEAF_W'(k));
    assign pop                                    = i_fifo_read[k] && (count != '0);
    assign full[k]                                = (count == CNT_W'(DEPTH));
    assign o_fifo_empty[k]                        = (count == '0);
    assign o_fifo[DATA_WIDTH*k +: DATA_WIDTH]     = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end

    always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= wr_data;
    end
  end

  assign o_idle = (state_q == IDLE) && (&o_fifo_empty);

endmodule

// File: tb/tb_leaf_feeder.sv
// Bench for leaf_feeder: directed scenarios plus random traffic, every cycle
// compared against a queue-per-leaf model of the feeder.
module tb_leaf_feeder;
  localparam int L     = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = 4;
  localparam int N     = 2 * L;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [DW-1:0]     i_data;
  logic              i_valid;
  logic [LW-1:0]     i_leaf;
  logic              i_last;
  logic              o_ready;
  logic [DW*N-1:0]   o_fifo;
  logic [N-1:0]      o_fifo_empty;
  logic [N-1:0]      i_fifo_read;
  logic              o_idle;

  always #5 i_clk = ~i_clk;

  leaf_feeder #(.L(L), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LEAF_W(LW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_leaf       (i_leaf),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_fifo       (o_fifo),
    .o_fifo_empty (o_fifo_empty),
    .i_fifo_read  (i_fifo_read),
    .o_idle       (o_idle)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one queue per leaf plus a pending-terminator flag.
  logic [DW-1:0] q [N][$];
  bit            term_pend = 0;
  int            term_leaf = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) q[k].delete();
    term_pend = 0;
    term_leaf = 0;
  endtask

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic cycle();
    logic [N-1:0]  exp_empty;
    bit            exp_ready;
    bit            wr;
    int            wl;
    logic [DW-1:0] wd;
    @(negedge i_clk);
    for (int k = 0; k < N; k++) exp_empty[k] = (q[k].size() == 0);
    exp_ready = !term_pend && (q[i_leaf].size() < DEPTH);
    chk("ready", o_ready, exp_ready);
    chk("empty", o_fifo_empty, exp_empty);
    chk("idle", o_idle, !term_pend && (exp_empty == '1));
    for (int k = 0; k < N; k++)
      if (q[k].size() > 0) chk($sformatf("head%0d", k), o_fifo[k*DW +: DW], q[k][0]);
    wr = 0;
    wl = 0;
    wd = '0;
    if (!term_pend) begin
      if (i_valid && exp_ready) begin
        wr = 1; wl = int'(i_leaf); wd = i_data;
        if (i_last) begin
          term_pend = 1;
          term_leaf = int'(i_leaf);
        end
      end
    end else if (q[term_leaf].size() < DEPTH) begin
      wr = 1; wl = term_leaf; wd = '0;
      term_pend = 0;
    end
    for (int k = 0; k < N; k++)
      if (i_fifo_read[k] && q[k].size() > 0) void'(q[k].pop_front());
    if (wr) q[wl].push_back(wd);
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    chk("rst_empty", o_fifo_empty, {N{1'b1}});
    chk("rst_idle", o_idle, 1'b1);
    chk("rst_ready", o_ready, 1'b1);
    model_clear();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic wr_rec(input int leaf, input logic [DW-1:0] d, input bit last);
    i_valid = 1'b1;
    i_leaf  = LW'(leaf);
    i_data  = d;
    i_last  = last;
    cycle();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic [N-1:0] rd);
    i_valid     = 1'b0;
    i_fifo_read = rd;
    repeat (n) cycle();
    i_fifo_read = '0;
  endtask

  initial begin
    i_rst = 1'b1; i_data = '0; i_valid = 1'b0; i_leaf = '0; i_last = 1'b0; i_fifo_read = '0;
    #12;
    chk("init_empty", o_fifo_empty, {N{1'b1}});
    chk("init_idle", o_idle, 1'b1);
    chk("init_ready", o_ready, 1'b1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Single write to leaf 3, then pop it.
    wr_rec(3, 32'h11, 0);
    idle_cycles(1, '0);
    idle_cycles(1, N'(1) << 3);

    // Run end on leaf 0: record then zero terminator.
    wr_rec(0, 32'h05, 1);
    idle_cycles(2, '0);
    idle_cycles(2, N'(1));
    idle_cycles(1, '0);

    // Fill leaf 7; fifth attempt blocked, leaf 6 still accepts.
    for (int i = 0; i < 4; i++) wr_rec(7, DW'(32'h70 + i), 0);
    wr_rec(7, 32'h7f, 0);
    wr_rec(6, 32'h66, 0);
    idle_cycles(4, (N'(1) << 7) | (N'(1) << 6));

    // Leaf 2 filled by the run end; terminator waits for a pop.
    for (int i = 0; i < 3; i++) wr_rec(2, DW'(32'h20 + i), 0);
    wr_rec(2, 32'h23, 1);
    idle_cycles(3, '0);
    idle_cycles(1, N'(1) << 2);
    idle_cycles(1, '0);
    idle_cycles(5, N'(1) << 2);

    // Concurrent write and pop on leaf 1 across pointer wrap.
    wr_rec(1, 32'h100, 0);
    wr_rec(1, 32'h101, 0);
    i_fifo_read = N'(1) << 1;
    for (int i = 0; i < 10; i++) wr_rec(1, DW'(32'h102 + i), 0);
    idle_cycles(3, N'(1) << 1);

    // Reset while a terminator is pending on a full leaf.
    wr_rec(4, 32'h44, 0);
    for (int i = 0; i < 3; i++) wr_rec(5, DW'(32'h50 + i), 0);
    wr_rec(5, 32'h53, 1);
    idle_cycles(1, '0);
    do_reset();
    idle_cycles(4, '0);

    // Random traffic.
    repeat (800) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_leaf  = LW'($urandom_range(0, N - 1));
      i_data  = $urandom;
      i_last  = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < N; k++) i_fifo_read[k] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
